// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. One result bit per cycle, shared datapath
// for shift-add multiply and restoring divide. The results go to the Hi/Lo registers.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic             is_div;      // latched op[1]
    logic             neg_lo;      // negate product / quotient in FIX
    logic             neg_hi;      // negate remainder in FIX
    logic [WIDTH-1:0] opnd;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;      // partial product upper / partial remainder
    logic [WIDTH-1:0] acc_lo;      // multiplier bits / dividend-quotient bits

    // Operand magnitudes at the start edge; unsigned ops pass through raw.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One multiply step: conditional add, then the whole accumulator shifts right.
    logic [WIDTH:0] add_sum;
    assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // One restoring-divide step. Since remainder < divisor, trial < 2*divisor,
    // so bit WIDTH of the difference is a reliable sign bit.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    assign trial = {acc_hi, acc_lo[WIDTH-1]};
    assign diff  = trial - {1'b0, opnd};

    logic [2*WIDTH-1:0] prod;
    assign prod = {acc_hi, acc_lo};

    // NOTE: all state is updated with non-blocking assignments in one clocked
    // block, so every register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            counter  <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    state    <= S_IDLE;
                    if (start) begin
                        is_div <= op[1];
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        acc_hi <= '0;
                        if (op[1]) begin
                            opnd   <= b_mag;
                            acc_lo <= a_mag;
                        end else begin
                            opnd   <= a_mag;
                            acc_lo <= b_mag;
                        end
                        if (op[1] && (b == '0)) begin
                            // hi/lo keep the previous result.
                            state    <= S_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state   <= S_CALC;
                            counter <= CW'(WIDTH - 1);
                            busy    <= 1'b1;
                        end
                    end
                end

                S_CALC: begin
                    if (!is_div) begin
                        acc_hi <= add_sum[WIDTH:1];
                        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    end else if (!diff[WIDTH]) begin
                        acc_hi <= diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    counter <= counter - 1'b1;
                    if (counter == '0) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= neg_lo ? -prod : prod;
                    end else begin
                        lo <= neg_lo ? -acc_lo : acc_lo;
                        hi <= neg_hi ? -acc_hi : acc_hi;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases from the plan plus
// random operations on a 32-bit and an 8-bit instance against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int total = 0;
    int bad   = 0;

    logic [63:0] last_hi32 = '0, last_lo32 = '0, last_hi8 = '0, last_lo8 = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference results from plain integer arithmetic on the signed/unsigned values.
    function automatic void model(input int w, input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] hi,
                                  output logic [63:0] lo, output bit dz);
        logic [63:0] mask;
        logic [63:0] ua, ub, pu;
        longint      sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = a & mask;
        ub   = b & mask;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        dz   = 1'b0;
        hi   = '0;
        lo   = '0;
        case (op)
            2'b00: begin
                p  = sa * sb;
                pu = p;
                hi = (pu >> w) & mask;
                lo = pu & mask;
            end
            2'b01: begin
                pu = ua * ub;
                hi = (pu >> w) & mask;
                lo = pu & mask;
            end
            2'b10: begin
                if (ub == 0) dz = 1'b1;
                else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q & mask;
                    hi = r & mask;
                end
            end
            default: begin
                if (ub == 0) dz = 1'b1;
                else begin
                    lo = ua / ub;
                    hi = ua % ub;
                end
            end
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        if (w == 8) begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = op; a32 = a[31:0]; b32 = b[31:0];
        end
    endtask

    task automatic set_start(input int w, input logic s);
        if (w == 8) start8 = s;
        else start32 = s;
    endtask

    function automatic logic o_busy(input int w);
        return (w == 8) ? busy8 : busy32;
    endfunction
    function automatic logic o_done(input int w);
        return (w == 8) ? done8 : done32;
    endfunction
    function automatic logic o_dz(input int w);
        return (w == 8) ? dz8 : dz32;
    endfunction
    function automatic logic [63:0] o_hi(input int w);
        return (w == 8) ? {56'd0, hi8} : {32'd0, hi32};
    endfunction
    function automatic logic [63:0] o_lo(input int w);
        return (w == 8) ? {56'd0, lo8} : {32'd0, lo32};
    endfunction

    // Launch one op, wait (bounded) for done, check latency, busy span and result.
    // chain=1 returns while the unit is in DONE so the next call starts back-to-back.
    // poke=1 pulses start with other operands while busy; it must be ignored.
    task automatic run_op(input string tag, input int w, input logic [1:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input bit chain, input bit poke);
        logic [63:0] eh, el;
        bit          dz;
        int          k;
        int          busy_cnt;
        bit          seen;
        model(w, op, a, b, eh, el, dz);
        if (dz) begin
            eh = (w == 8) ? last_hi8 : last_hi32;
            el = (w == 8) ? last_lo8 : last_lo32;
        end
        drive(w, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, $urandom_range(0, 3), {$urandom, $urandom}, {$urandom, $urandom});
        k = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (k <= w + 8) begin
            if (o_done(w)) begin
                seen = 1'b1;
                break;
            end
            if (o_busy(w)) busy_cnt++;
            if (poke && k == 4) drive(w, 1'b1, op ^ 2'b01, {$urandom, $urandom}, 64'd1);
            if (poke && k == 5) set_start(w, 1'b0);
            @(posedge clk); #1;
            k++;
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, " latency"}, 64'(k), dz ? 64'd0 : 64'(w + 1));
            check({tag, " busy_cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'(w + 1));
            check({tag, " busy_at_done"}, 64'(o_busy(w)), 64'd0);
            check({tag, " div_zero"}, 64'(o_dz(w)), 64'(dz));
            check({tag, " hi"}, o_hi(w), eh);
            check({tag, " lo"}, o_lo(w), el);
        end
        if (w == 8) begin
            last_hi8 = eh; last_lo8 = el;
        end else begin
            last_hi32 = eh; last_lo32 = el;
        end
        if (!chain) begin
            @(posedge clk); #1;
            check({tag, " done_one_cycle"}, 64'(o_done(w)), 64'd0);
            check({tag, " hi_hold"}, o_hi(w), eh);
        end
    endtask

    initial begin
        int dcount;
        logic [63:0] corners [6];
        corners[0] = 64'h0;
        corners[1] = 64'h1;
        corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        corners[3] = 64'h8000_0000;
        corners[4] = 64'h7FFF_FFFF;
        corners[5] = 64'h80;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset div_zero", 64'(dz32), 64'd0);
        check("reset hi", 64'(hi32), 64'd0);
        check("reset lo", 64'(lo32), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op("mult_neg3x7", 32, 2'b00, 64'hFFFF_FFFD, 64'd7, 1'b0, 1'b0);
        run_op("multu_max", 32, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("multu_b2b", 32, 2'b01, 64'd2, 64'd3, 1'b0, 1'b0);
        check("multu_b2b lo value", 64'(lo32), 64'd6);
        run_op("div_neg7by2", 32, 2'b10, 64'hFFFF_FFF9, 64'd2, 1'b0, 1'b0);
        check("div_neg7by2 lo value", 64'(lo32), 64'hFFFF_FFFD);
        check("div_neg7by2 hi value", 64'(hi32), 64'hFFFF_FFFF);
        run_op("divu_100by7", 32, 2'b11, 64'd100, 64'd7, 1'b0, 1'b0);
        run_op("divu_by_zero", 32, 2'b11, 64'd5, 64'd0, 1'b0, 1'b0);
        check("divu_by_zero hi kept", 64'(hi32), 64'd2);
        check("divu_by_zero lo kept", 64'(lo32), 64'd14);
        run_op("div_minneg", 32, 2'b10, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_minneg lo value", 64'(lo32), 64'h8000_0000);
        run_op("div_zero_signed", 32, 2'b10, 64'hFFFF_FFF0, 64'd0, 1'b1, 1'b0);
        run_op("after_dz_b2b", 32, 2'b10, 64'd9, 64'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("mult_ignore_start", 32, 2'b00, 64'h1234_5678, 64'hFFFF_0001, 1'b0, 1'b1);
        run_op("mult8_neg3x7", 8, 2'b00, 64'hFD, 64'h07, 1'b0, 1'b0);
        check("mult8 hi value", 64'(hi8), 64'hFF);
        check("mult8 lo value", 64'(lo8), 64'hEB);
        run_op("div8_minneg", 8, 2'b10, 64'h80, 64'hFF, 1'b0, 1'b0);

        // Random operations with occasional corner operands and zero divisors.
        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : {32'd0, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? 64'd0 :
                 ($urandom_range(0, 3) == 0) ? corners[$urandom_range(1, 5)] : {32'd0, $urandom};
            run_op($sformatf("rand32_%0d", i), 32, 2'($urandom_range(0, 3)), ra, rb,
                   bit'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            logic [63:0] ra, rb;
            ra = {56'd0, 8'($urandom)};
            rb = ($urandom_range(0, 7) == 0) ? 64'd0 : {56'd0, 8'($urandom)};
            run_op($sformatf("rand8_%0d", i), 8, 2'($urandom_range(0, 3)), ra, rb,
                   bit'($urandom_range(0, 1)), 1'b0);
        end
        @(posedge clk); #1;

        // Abort an op with reset ten cycles after start.
        drive(32, 1'b1, 2'b00, 64'hFFFF_FFFD, 64'd7);
        @(posedge clk); #1;
        set_start(32, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("abort busy_before", 64'(busy32), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 64'(busy32), 64'd0);
        check("abort done", 64'(done32), 64'd0);
        check("abort hi", 64'(hi32), 64'd0);
        check("abort lo", 64'(lo32), 64'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32 || busy32) dcount++;
        end
        check("abort no_done_pulse", 64'(dcount), 64'd0);
        last_hi32 = '0; last_lo32 = '0; last_hi8 = '0; last_lo8 = '0;
        run_op("post_reset_divu", 32, 2'b11, 64'd100, 64'd7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
